// File: rtl/sda_gmem_read_arbiter.sv
// -----------------------------------------------------------------------------
// sda_gmem_read_arbiter
//
// Shares one AXI master read path (m_axi_gmem AR/R) between NumPorts
// requesters. One burst is granted at a time. The grant is held from
// arbitration until the accepted RLAST beat. Every accepted R beat is checked
// against the granted ARLEN, and any length mismatch sets a sticky len_err.
//
// Ports
//   ap_clk, ap_rst_n      clock, synchronous active-low reset
//   s_ARADDR/ARLEN/ARVALID/ARREADY   per-requester AR channel (slice i = port i)
//   s_RDATA/RRESP/RLAST   R payload, broadcast to all requesters
//   s_RVALID/RREADY       per-requester R handshake
//   m_axi_gmem_*          shared master AR/R channel
//   grant                 one-hot current owner (0 when idle)
//   busy                  high whenever the FSM is not IDLE
//   len_err               sticky burst-length mismatch flag
//
// Build option: define GMEM_ARB_FIXED_PRIORITY_EN for fixed priority
// (lowest index wins, rr_ptr held at 0). Default build is round-robin.
// -----------------------------------------------------------------------------
module sda_gmem_read_arbiter #(
    parameter int NumPorts  = 2,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [NumPorts*AddrWidth-1:0] s_ARADDR,
    input  logic [NumPorts*8-1:0]         s_ARLEN,
    input  logic [NumPorts-1:0]           s_ARVALID,
    output logic [NumPorts-1:0]           s_ARREADY,
    output logic [DataWidth-1:0]          s_RDATA,
    output logic [1:0]                    s_RRESP,
    output logic                          s_RLAST,
    output logic [NumPorts-1:0]           s_RVALID,
    input  logic [NumPorts-1:0]           s_RREADY,
    output logic [AddrWidth-1:0]          m_axi_gmem_ARADDR,
    output logic [7:0]                    m_axi_gmem_ARLEN,
    output logic                          m_axi_gmem_ARVALID,
    input  logic                          m_axi_gmem_ARREADY,
    input  logic [DataWidth-1:0]          m_axi_gmem_RDATA,
    input  logic [1:0]                    m_axi_gmem_RRESP,
    input  logic                          m_axi_gmem_RLAST,
    input  logic                          m_axi_gmem_RVALID,
    output logic                          m_axi_gmem_RREADY,
    output logic [NumPorts-1:0]           grant,
    output logic                          busy,
    output logic                          len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state_q, state_d;
    logic [NumPorts-1:0]   grant_q, grant_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic [7:0]            beats_left_q, beats_left_d;
    logic                  len_err_q, len_err_d;

    int                    gidx;
    int                    win_idx;
    logic                  win_found;
    logic                  beat_acc;

    // Index of the current owner, decoded from the one-hot grant register.
    always_comb begin
        gidx = 0;
        for (int i = 0; i < NumPorts; i++) begin
            if (grant_q[i]) gidx = i;
        end
    end

    // Winner search: walk upward from the start index with wrap and take the
    // first requester with ARVALID set.
    always_comb begin
        int start;
        int idx;
        win_idx   = 0;
        win_found = 1'b0;
`ifdef GMEM_ARB_FIXED_PRIORITY_EN
        start = 0;
`else
        start = int'(rr_ptr_q);
`endif
        for (int k = 0; k < NumPorts; k++) begin
            idx = start + k;
            if (idx >= NumPorts) idx = idx - NumPorts;
            if (!win_found && s_ARVALID[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // R payload goes straight through; only the valid is steered.
    assign s_RDATA = m_axi_gmem_RDATA;
    assign s_RRESP = m_axi_gmem_RRESP;
    assign s_RLAST = m_axi_gmem_RLAST;

    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign len_err = len_err_q;

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        rr_ptr_d           = rr_ptr_q;
        beats_left_d       = beats_left_q;
        len_err_d          = len_err_q;
        s_ARREADY          = '0;
        s_RVALID           = '0;
        m_axi_gmem_ARADDR  = '0;
        m_axi_gmem_ARLEN   = '0;
        m_axi_gmem_ARVALID = 1'b0;
        m_axi_gmem_RREADY  = 1'b0;
        beat_acc           = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    beats_left_d     = s_ARLEN[win_idx*8 +: 8];
                    state_d          = ADDR;
                end
            end
            ADDR: begin
                m_axi_gmem_ARADDR  = s_ARADDR[gidx*AddrWidth +: AddrWidth];
                m_axi_gmem_ARLEN   = s_ARLEN[gidx*8 +: 8];
                m_axi_gmem_ARVALID = s_ARVALID[gidx];
                s_ARREADY[gidx]    = m_axi_gmem_ARREADY;
                if (s_ARVALID[gidx] && m_axi_gmem_ARREADY) state_d = DATA;
            end
            DATA: begin
                s_RVALID[gidx]    = m_axi_gmem_RVALID;
                m_axi_gmem_RREADY = s_RREADY[gidx];
                beat_acc          = m_axi_gmem_RVALID && s_RREADY[gidx];
                if (beat_acc) begin
                    // Saturating countdown: an over-long burst must not wrap.
                    if (beats_left_q != 8'd0) beats_left_d = beats_left_q - 8'd1;
                    if (m_axi_gmem_RLAST != (beats_left_q == 8'd0)) len_err_d = 1'b1;
                    if (m_axi_gmem_RLAST) begin
                        state_d = IDLE;
                        grant_d = '0;
`ifdef GMEM_ARB_FIXED_PRIORITY_EN
                        rr_ptr_d = 2'd0;
`else
                        rr_ptr_d = (gidx == NumPorts - 1) ? 2'd0 : 2'(gidx + 1);
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= 2'd0;
            beats_left_q <= 8'd0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            beats_left_q <= beats_left_d;
            len_err_q    <= len_err_d;
        end
    end

endmodule

// File: tb/tb_sda_gmem_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sda_gmem_read_arbiter
//
// Directed bench for sda_gmem_read_arbiter with two requesters. Inputs change
// 1 ns after the rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_sda_gmem_read_arbiter;

    localparam int NP = 2;
    localparam int AW = 64;
    localparam int DW = 64;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic [NP*AW-1:0]  s_ARADDR;
    logic [NP*8-1:0]   s_ARLEN;
    logic [NP-1:0]     s_ARVALID;
    logic [NP-1:0]     s_ARREADY;
    logic [DW-1:0]     s_RDATA;
    logic [1:0]        s_RRESP;
    logic              s_RLAST;
    logic [NP-1:0]     s_RVALID;
    logic [NP-1:0]     s_RREADY;
    logic [AW-1:0]     m_ARADDR;
    logic [7:0]        m_ARLEN;
    logic              m_ARVALID;
    logic              m_ARREADY;
    logic [DW-1:0]     m_RDATA;
    logic [1:0]        m_RRESP;
    logic              m_RLAST;
    logic              m_RVALID;
    logic              m_RREADY;
    logic [NP-1:0]     grant;
    logic              busy;
    logic              len_err;

    int errors = 0;
    int checks = 0;

    always #5 ap_clk = ~ap_clk;

    sda_gmem_read_arbiter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW)) dut (
        .ap_clk             (ap_clk),
        .ap_rst_n           (ap_rst_n),
        .s_ARADDR           (s_ARADDR),
        .s_ARLEN            (s_ARLEN),
        .s_ARVALID          (s_ARVALID),
        .s_ARREADY          (s_ARREADY),
        .s_RDATA            (s_RDATA),
        .s_RRESP            (s_RRESP),
        .s_RLAST            (s_RLAST),
        .s_RVALID           (s_RVALID),
        .s_RREADY           (s_RREADY),
        .m_axi_gmem_ARADDR  (m_ARADDR),
        .m_axi_gmem_ARLEN   (m_ARLEN),
        .m_axi_gmem_ARVALID (m_ARVALID),
        .m_axi_gmem_ARREADY (m_ARREADY),
        .m_axi_gmem_RDATA   (m_RDATA),
        .m_axi_gmem_RRESP   (m_RRESP),
        .m_axi_gmem_RLAST   (m_RLAST),
        .m_axi_gmem_RVALID  (m_RVALID),
        .m_axi_gmem_RREADY  (m_RREADY),
        .grant              (grant),
        .busy               (busy),
        .len_err            (len_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Runs one burst from IDLE with the requests already presented: grant,
    // AR handshake, then nbeats R beats with RLAST on the last one.
    task automatic run_burst(input string tag, input logic [1:0] exp_g,
                             input logic [7:0] exp_len, input logic [63:0] exp_addr,
                             input int nbeats);
        tick();
        check({tag, "_grant"}, 64'(grant), 64'(exp_g));
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_arvalid"}, 64'(m_ARVALID), 64'd1);
        check({tag, "_araddr"}, m_ARADDR, exp_addr);
        check({tag, "_arlen"}, 64'(m_ARLEN), 64'(exp_len));
        m_ARREADY = 1'b1;
        #1;
        check({tag, "_arready"}, 64'(s_ARREADY), 64'(exp_g));
        tick();
        m_ARREADY = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            m_RVALID = 1'b1;
            m_RLAST  = (b == nbeats - 1);
            m_RDATA  = 64'hD000_0000 + 64'(b);
            #1;
            check({tag, "_rvalid"}, 64'(s_RVALID), 64'(exp_g));
            check({tag, "_rdata"}, s_RDATA, 64'hD000_0000 + 64'(b));
            tick();
        end
        m_RVALID = 1'b0;
        m_RLAST  = 1'b0;
        #1;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_grant"}, 64'(grant), 64'd0);
    endtask

    logic [1:0] exp_seq [4];

    initial begin
`ifdef GMEM_ARB_FIXED_PRIORITY_EN
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        ap_rst_n  = 1'b0;
        s_ARADDR  = '0;
        s_ARLEN   = '0;
        s_ARVALID = '0;
        s_RREADY  = '1;
        m_ARREADY = 1'b0;
        m_RDATA   = '0;
        m_RRESP   = 2'b00;
        m_RLAST   = 1'b0;
        m_RVALID  = 1'b0;

        // Reset
        tick();
        tick();
        ap_rst_n = 1'b1;
        #1;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_arvalid", 64'(m_ARVALID), 64'd0);
        check("rst_araddr", m_ARADDR, 64'd0);
        check("rst_rready", 64'(m_RREADY), 64'd0);
        check("rst_s_arready", 64'(s_ARREADY), 64'd0);

        // Contention: both ports request ARLEN=0 continuously
        s_ARADDR  = {64'h200, 64'h100};
        s_ARLEN   = {8'd0, 8'd0};
        s_ARVALID = 2'b11;
        #1;
        check("req_busy_not_yet", 64'(busy), 64'd0);
        for (int n = 0; n < 4; n++) begin
            run_burst($sformatf("cont%0d", n), exp_seq[n], 8'd0,
                      (exp_seq[n] == 2'b01) ? 64'h100 : 64'h200, 1);
        end
        check("cont_len_err", 64'(len_err), 64'd0);

        // Single burst, port 0, ARLEN=3
        s_ARVALID = 2'b01;
        s_ARADDR  = {64'h0, 64'h1000};
        s_ARLEN   = {8'd0, 8'd3};
        run_burst("single", 2'b01, 8'd3, 64'h1000, 4);
        s_ARVALID = 2'b00;
        check("single_len_err", 64'(len_err), 64'd0);

        // Backpressure: port 1, ARLEN=3, RREADY low 5 cycles after beat 0
        s_ARVALID = 2'b10;
        s_ARADDR  = {64'h2000, 64'h0};
        s_ARLEN   = {8'd3, 8'd0};
        tick();
        check("bp_grant", 64'(grant), 64'd2);
        check("bp_araddr", m_ARADDR, 64'h2000);
        m_ARREADY = 1'b1;
        tick();
        m_ARREADY = 1'b0;
        s_ARVALID = 2'b00;
        m_RVALID  = 1'b1;
        tick();
        s_RREADY = 2'b00;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_stall%0d_rready", c), 64'(m_RREADY), 64'd0);
            check($sformatf("bp_stall%0d_rvalid", c), 64'(s_RVALID), 64'd2);
            tick();
        end
        s_RREADY = 2'b11;
        for (int b = 1; b < 4; b++) begin
            m_RLAST = (b == 3);
            #1;
            check($sformatf("bp_beat%0d_rready", b), 64'(m_RREADY), 64'd1);
            tick();
        end
        m_RVALID = 1'b0;
        m_RLAST  = 1'b0;
        #1;
        check("bp_busy", 64'(busy), 64'd0);
        check("bp_len_err", 64'(len_err), 64'd0);

        // Length error: ARLEN=3 with RLAST on the third beat
        s_ARVALID = 2'b01;
        s_ARADDR  = {64'h0, 64'h3000};
        s_ARLEN   = {8'd0, 8'd3};
        run_burst("short", 2'b01, 8'd3, 64'h3000, 3);
        s_ARVALID = 2'b00;
        check("short_len_err", 64'(len_err), 64'd1);

        // A later good burst leaves the sticky flag set
        s_ARVALID = 2'b10;
        s_ARADDR  = {64'h4000, 64'h0};
        s_ARLEN   = {8'd1, 8'd0};
        run_burst("good_after", 2'b10, 8'd1, 64'h4000, 2);
        s_ARVALID = 2'b00;
        check("sticky_len_err", 64'(len_err), 64'd1);

        // Reset mid-DATA of an ARLEN=7 burst
        s_ARVALID = 2'b01;
        s_ARADDR  = {64'h0, 64'h5000};
        s_ARLEN   = {8'd0, 8'd7};
        tick();
        m_ARREADY = 1'b1;
        tick();
        m_ARREADY = 1'b0;
        s_ARVALID = 2'b00;
        m_RVALID  = 1'b1;
        tick();
        tick();
        #1;
        check("mid_busy_before", 64'(busy), 64'd1);
        check("mid_rready_before", 64'(m_RREADY), 64'd1);
        ap_rst_n = 1'b0;
        tick();
        check("mid_rst_grant", 64'(grant), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rready", 64'(m_RREADY), 64'd0);
        check("mid_rst_len_err", 64'(len_err), 64'd0);
        m_RVALID = 1'b0;
        ap_rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
